seven_seg_mux_driver: RTL and testbench

Time-multiplexed driver for a chain of N seven-segment digits behind a 16-bit serial-in shift register: upper byte is a one-hot digit select, lower byte is the segment pattern. It is the parametrised successor of the fixed three-digit top-level multiplexer. Digit count, shift-clock rate, hold time and output polarities are parameters. It adds an internal serializer, frame-coherent value snapshots, decimal points, leading-zero blanking, enable control and a frame-done strobe. It sits between a numeric source (counter, register) and board pins.

---
 rtl/seven_seg_mux_driver.sv | 231 +++++++++++++++++++++++
 tb/tb_seven_seg_mux_driver.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_mux_driver.sv
// Time-multiplexed seven-segment driver: serialises one {select, segment} word per
// digit into an external 16-bit shift register, latches it, then holds it on the pins.
module seven_seg_mux_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 8,
    parameter int DIGIT_HOLD     = 2048,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic                    i_blank_leading,
    input  logic                    i_enable,
    output logic                    o_data,
    output logic                    o_data_clk,
    output logic                    o_latch,
    output logic                    o_busy,
    output logic                    o_frame_done
);

    localparam int BIT_PERIOD = 2 * CLK_DIV;
    localparam int CNT_MAX    = (BIT_PERIOD > DIGIT_HOLD) ? BIT_PERIOD : DIGIT_HOLD;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CLK_HIGH   = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(DIGIT_HOLD - 1);
    localparam logic [IDX_W-1:0] DIGIT_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH,
        ST_HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        digit_q, digit_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [3:0]              bit_q, bit_d;
    logic [15:0]             word_q, word_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic                    blank_q, blank_d;
    logic                    frame_done_q, frame_done_d;

    // Digit 0's LOAD is the snapshot cycle, so it must already see the live inputs.
    logic [4*NUM_DIGITS-1:0] value_eff;
    logic [NUM_DIGITS-1:0]   dp_eff;
    logic                    blank_eff;

    assign value_eff = (digit_q == '0) ? i_value         : value_q;
    assign dp_eff    = (digit_q == '0) ? i_dp            : dp_q;
    assign blank_eff = (digit_q == '0) ? i_blank_leading : blank_q;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // A digit is blanked only while it and everything above it are zero.
    logic [NUM_DIGITS-1:0] blank_vec;

    always_comb begin
        logic all_zero;
        all_zero  = 1'b1;
        blank_vec = '0;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            all_zero     = all_zero & (value_eff[4*d +: 4] == 4'h0);
            blank_vec[d] = blank_eff & all_zero & (d != 0);
        end
    end

    logic [7:0] seg_pattern [NUM_DIGITS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg
            assign seg_pattern[gi] = {dp_eff[gi],
                                      blank_vec[gi] ? 7'h00 : hex_to_seg(value_eff[4*gi +: 4])};
        end
    endgenerate

    logic [7:0]  sel_raw;
    logic [7:0]  seg_raw;
    logic [15:0] word_build;

    always_comb begin
        sel_raw    = 8'b1 << digit_q;
        seg_raw    = seg_pattern[digit_q];
        word_build = {SEL_ACTIVE_LOW ? ~sel_raw : sel_raw,
                      SEG_ACTIVE_LOW ? ~seg_raw : seg_raw};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            digit_q      <= '0;
            cnt_q        <= '0;
            bit_q        <= '0;
            word_q       <= '0;
            value_q      <= '0;
            dp_q         <= '0;
            blank_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            digit_q      <= digit_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            word_q       <= word_d;
            value_q      <= value_d;
            dp_q         <= dp_d;
            blank_q      <= blank_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        digit_d      = digit_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        word_d       = word_q;
        value_d      = value_q;
        dp_d         = dp_q;
        blank_d      = blank_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    state_d = ST_LOAD;
                    digit_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                word_d  = word_build;
                bit_d   = 4'd15;
                cnt_d   = '0;
                state_d = ST_SHIFT;
                if (digit_q == '0) begin
                    value_d = i_value;
                    dp_d    = i_dp;
                    blank_d = i_blank_leading;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 4'd0) begin
                        state_d = ST_LATCH;
                    end else begin
                        bit_d = bit_q - 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (digit_q == DIGIT_LAST) begin
                        frame_done_d = 1'b1;
                        digit_d      = '0;
                        state_d      = i_enable ? ST_LOAD : ST_IDLE;
                    end else begin
                        digit_d = digit_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                digit_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Shift clock rises halfway through each bit, so data only moves while it is low.
    always_comb begin
        o_data       = 1'b0;
        o_data_clk   = 1'b0;
        o_latch      = 1'b0;
        o_busy       = (state_q != ST_IDLE);
        o_frame_done = frame_done_q;
        if (state_q == ST_SHIFT) begin
            o_data     = word_q[bit_q];
            o_data_clk = (cnt_q >= CLK_HIGH);
        end
        if (state_q == ST_LATCH) begin
            o_latch = 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// Directed bench: decodes the serial stream back into 16-bit words and checks words,
// frame timing, enable/reset behaviour and output polarity.
module tb_seven_seg_mux_driver;

    localparam int NA = 4;
    localparam int C  = 2;
    localparam int H  = 4;
    localparam int DIGIT_PERIOD = 1 + 32*C + C + H;
    localparam int FRAME_PERIOD = NA * DIGIT_PERIOD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, blank_a = 1'b0, en_a = 1'b0;
    logic [15:0] val_a = '0;
    logic [3:0]  dp_a  = '0;
    logic        data_a, dclk_a, latch_a, busy_a, fd_a;

    logic        rst_b = 1'b1, blank_b = 1'b0, en_b = 1'b0;
    logic [7:0]  val_b = '0;
    logic [1:0]  dp_b  = '0;
    logic        data_b, dclk_b, latch_b, busy_b, fd_b;

    seven_seg_mux_driver #(.NUM_DIGITS(NA), .CLK_DIV(C), .DIGIT_HOLD(H),
                           .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)) dut_a (
        .i_clk(clk), .i_reset(rst_a), .i_value(val_a), .i_dp(dp_a),
        .i_blank_leading(blank_a), .i_enable(en_a),
        .o_data(data_a), .o_data_clk(dclk_a), .o_latch(latch_a),
        .o_busy(busy_a), .o_frame_done(fd_a)
    );

    seven_seg_mux_driver #(.NUM_DIGITS(2), .CLK_DIV(C), .DIGIT_HOLD(H),
                           .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) dut_b (
        .i_clk(clk), .i_reset(rst_b), .i_value(val_b), .i_dp(dp_b),
        .i_blank_leading(blank_b), .i_enable(en_b),
        .o_data(data_b), .o_data_clk(dclk_b), .o_latch(latch_b),
        .o_busy(busy_b), .o_frame_done(fd_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor A: models the external shift register, timestamps latches and frame_done.
    logic        pdclk_a = 1'b0, platch_a = 1'b0, pfd_a = 1'b0, pdata_a = 1'b0;
    logic [15:0] sh_a = '0;
    logic [15:0] words_a [$];
    int          latch_t_a [$];
    int          fd_t_a [$];
    logic        fd_busy_a [$];
    int          viol_a = 0, bad_hi_a = 0, bad_lat_a = 0, fd_long_a = 0, rises_a = 0;
    int          hi_cnt_a = 0, lat_cnt_a = 0;

    always @(negedge clk) begin
        if (dclk_a && !pdclk_a) begin
            sh_a = {sh_a[14:0], data_a};
            rises_a++;
        end
        if (dclk_a && pdclk_a && data_a !== pdata_a) viol_a++;
        if (latch_a && !platch_a) begin
            words_a.push_back(sh_a);
            latch_t_a.push_back(cyc);
        end
        if (fd_a && !pfd_a) begin
            fd_t_a.push_back(cyc);
            fd_busy_a.push_back(busy_a);
        end
        if (fd_a && pfd_a) fd_long_a++;
        if (dclk_a) hi_cnt_a++;
        else begin
            if (pdclk_a && hi_cnt_a != C) bad_hi_a++;
            hi_cnt_a = 0;
        end
        if (latch_a) lat_cnt_a++;
        else begin
            if (platch_a && lat_cnt_a != C) bad_lat_a++;
            lat_cnt_a = 0;
        end
        pdclk_a  = dclk_a;
        platch_a = latch_a;
        pfd_a    = fd_a;
        pdata_a  = data_a;
    end

    logic        pdclk_b = 1'b0, platch_b = 1'b0;
    logic [15:0] sh_b = '0;
    logic [15:0] words_b [$];

    always @(negedge clk) begin
        if (dclk_b && !pdclk_b) sh_b = {sh_b[14:0], data_b};
        if (latch_b && !platch_b) words_b.push_back(sh_b);
        pdclk_b  = dclk_b;
        platch_b = latch_b;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_words_a(input int target, input int budget, input string name);
        int k = 0;
        while (words_a.size() < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (words_a.size() < target) begin
            checks++;
            errors++;
            $display("FAIL %s timeout words=%0d required=%0d", name, words_a.size(), target);
        end
    endtask

    task automatic wait_fd_a(input int target, input int budget, input string name);
        int k = 0;
        while (fd_t_a.size() < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (fd_t_a.size() < target) begin
            checks++;
            errors++;
            $display("FAIL %s timeout pulses=%0d required=%0d", name, fd_t_a.size(), target);
        end
    endtask

    function automatic logic [15:0] word_at_a(input int idx);
        return (idx < words_a.size()) ? words_a[idx] : 16'hxxxx;
    endfunction

    task automatic restart_a(input logic [15:0] v, input logic [3:0] dp, input logic bl);
        val_a   = v;
        dp_a    = dp;
        blank_a = bl;
        en_a    = 1'b1;
        rst_a   = 1'b1;
        tick(2);
        rst_a   = 1'b0;
    endtask

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        blank;
        logic [63:0] words;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int bw, bl, bf, t_busy, busy_seen, r0, v0, h0, l0, f0;

        vecs[0] = '{16'h0123, 4'b0000, 1'b0, {16'h083F, 16'h0406, 16'h025B, 16'h014F}};
        vecs[1] = '{16'h0040, 4'b1000, 1'b1, {16'h0880, 16'h0400, 16'h0266, 16'h013F}};
        vecs[2] = '{16'hFEDC, 4'b0101, 1'b1, {16'h0871, 16'h04F9, 16'h025E, 16'h01B9}};
        vecs[3] = '{16'h0000, 4'b0000, 1'b1, {16'h0800, 16'h0400, 16'h0200, 16'h013F}};
        vecs[4] = '{16'h0A05, 4'b0010, 1'b1, {16'h0800, 16'h0477, 16'h02BF, 16'h016D}};
        vecs[5] = '{16'h89B7, 4'b0000, 1'b0, {16'h087F, 16'h046F, 16'h027C, 16'h0107}};
        vecs[6] = '{16'h6000, 4'b0000, 1'b1, {16'h087D, 16'h043F, 16'h023F, 16'h013F}};

        // Reset and idle
        tick(3);
        check("reset_outputs", {data_a, dclk_a, latch_a, busy_a, fd_a}, 5'b0);
        rst_a = 1'b0;
        busy_seen = 0;
        repeat (100) begin
            tick(1);
            if (busy_a || data_a || dclk_a || latch_a || fd_a) busy_seen = 1;
        end
        check("idle_quiet_100", busy_seen, 0);
        $display("idle: busy stayed low for 100 cycles");

        // Basic frame timing with enable latency
        val_a = 16'h0123;
        dp_a  = 4'b0000;
        blank_a = 1'b0;
        bw = words_a.size();
        bl = latch_t_a.size();
        bf = fd_t_a.size();
        v0 = viol_a; h0 = bad_hi_a; l0 = bad_lat_a; f0 = fd_long_a;
        en_a = 1'b1;
        check("busy_before_enable", busy_a, 0);
        tick(1);
        check("busy_after_enable", busy_a, 1);
        t_busy = cyc;
        wait_fd_a(bf + 3, 4 * FRAME_PERIOD, "frame_done_wait");
        if (fd_t_a.size() >= bf + 3) begin
            check("first_latch_latency", latch_t_a[bl] - t_busy, 65);
            check("digit_period", latch_t_a[bl+1] - latch_t_a[bl], DIGIT_PERIOD);
            check("digit_period_across_frame", latch_t_a[bl+4] - latch_t_a[bl+3], DIGIT_PERIOD);
            check("fd_after_last_latch", fd_t_a[bf] - latch_t_a[bl+3], C + H);
            check("frame_period_1", fd_t_a[bf+1] - fd_t_a[bf], FRAME_PERIOD);
            check("frame_period_2", fd_t_a[bf+2] - fd_t_a[bf+1], FRAME_PERIOD);
            check("fd_with_load_busy", fd_busy_a[bf], 1);
            $display("timing: frame_done at %0d %0d %0d", fd_t_a[bf], fd_t_a[bf+1], fd_t_a[bf+2]);
        end
        check("data_stable_while_clk_high", viol_a - v0, 0);
        check("data_clk_high_len", bad_hi_a - h0, 0);
        check("latch_len", bad_lat_a - l0, 0);
        check("frame_done_one_cycle", fd_long_a - f0, 0);

        // Table-driven word checks
        for (int i = 0; i < 7; i++) begin
            restart_a(vecs[i].value, vecs[i].dp, vecs[i].blank);
            bw = words_a.size();
            wait_words_a(bw + 4, 2 * FRAME_PERIOD, $sformatf("vec%0d_wait", i));
            for (int j = 0; j < 4; j++)
                check($sformatf("vec%0d_word%0d", i, j), word_at_a(bw + j), vecs[i].words[16*j +: 16]);
            $display("vec %0d value=%h dp=%b blank=%0d words %h %h %h %h", i, vecs[i].value,
                     vecs[i].dp, vecs[i].blank, word_at_a(bw), word_at_a(bw+1),
                     word_at_a(bw+2), word_at_a(bw+3));
        end

        // Coherence: a mid-frame value change waits for the next frame
        restart_a(16'h1111, 4'b0000, 1'b0);
        bw = words_a.size();
        wait_words_a(bw + 1, 2 * DIGIT_PERIOD, "coh_first_word");
        tick(10);
        val_a = 16'h2222;
        wait_words_a(bw + 8, 3 * FRAME_PERIOD, "coh_wait");
        check("coh_f0_d0", word_at_a(bw + 0), 16'h0106);
        check("coh_f0_d1", word_at_a(bw + 1), 16'h0206);
        check("coh_f0_d2", word_at_a(bw + 2), 16'h0406);
        check("coh_f0_d3", word_at_a(bw + 3), 16'h0806);
        check("coh_f1_d0", word_at_a(bw + 4), 16'h015B);
        check("coh_f1_d1", word_at_a(bw + 5), 16'h025B);
        check("coh_f1_d2", word_at_a(bw + 6), 16'h045B);
        check("coh_f1_d3", word_at_a(bw + 7), 16'h085B);
        $display("coherence: frame0 d1=%h frame1 d1=%h", word_at_a(bw + 1), word_at_a(bw + 5));

        // Dropping enable mid-frame still completes the frame
        restart_a(16'h0123, 4'b0000, 1'b0);
        bw = words_a.size();
        bf = fd_t_a.size();
        tick(20);
        en_a = 1'b0;
        wait_fd_a(bf + 1, 2 * FRAME_PERIOD, "drop_fd_wait");
        check("drop_words_complete", words_a.size() - bw, 4);
        if (fd_busy_a.size() > bf) check("drop_idle_at_fd", fd_busy_a[bf], 0);
        tick(100);
        check("drop_no_more_words", words_a.size() - bw, 4);
        check("drop_busy_low", busy_a, 0);
        check("drop_single_fd", fd_t_a.size() - bf, 1);
        $display("enable drop: words=%0d pulses=%0d", words_a.size() - bw, fd_t_a.size() - bf);

        // Reset during the eighth shifted bit
        restart_a(16'h0123, 4'b0000, 1'b0);
        r0 = rises_a;
        begin
            int k = 0;
            while (rises_a < r0 + 8 && k < 200) begin
                tick(1);
                k++;
            end
        end
        check("reached_bit7", rises_a - r0, 8);
        rst_a = 1'b1;
        tick(1);
        check("midshift_reset_outputs", {data_a, dclk_a, latch_a, busy_a, fd_a}, 5'b0);
        bw = words_a.size();
        rst_a = 1'b0;
        wait_words_a(bw + 1, 2 * DIGIT_PERIOD, "post_reset_wait");
        check("post_reset_first_word", word_at_a(bw), 16'h014F);
        $display("reset mid-shift: first word after release %h", word_at_a(bw));

        // Active-low polarity on a two-digit instance
        val_b = 8'h08;
        dp_b  = 2'b00;
        blank_b = 1'b0;
        en_b  = 1'b1;
        rst_b = 1'b0;
        begin
            int k = 0;
            while (words_b.size() < 2 && k < 4 * DIGIT_PERIOD) begin
                tick(1);
                k++;
            end
        end
        check("pol_word_count", words_b.size() >= 2, 1);
        check("pol_word0", (words_b.size() > 0) ? words_b[0] : 16'hxxxx, 16'hFE80);
        check("pol_word1", (words_b.size() > 1) ? words_b[1] : 16'hxxxx, 16'hFDC0);
        $display("polarity: words %h %h", (words_b.size() > 0) ? words_b[0] : 16'h0,
                 (words_b.size() > 1) ? words_b[1] : 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
